// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter increment arbiter.
package counter_ctrl_pkg;

  localparam int N_MAX = 8;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first set request bit scanning upward from base,
// wrapping N-1 -> 0. Purely combinational.
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  int   p;
  logic found;

  // Walk N positions from base; the first hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(base) + k;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found     = 1'b1;
        onehot[p] = 1'b1;
        idx       = IW'(p);
      end
    end
  end

endmodule

// File: rtl/counter_increment_arbiter.sv
// Shares one Increase strobe of the counter datapath between N requesters.
// Requests are latched into pending, served round-robin, and each grant gives
// one registered Increase pulse followed by GAP_CYCLES idle cycles.
// Optional build macro CNT_ARB_DROP_DETECT_EN adds the sticky dropped[] output
// flagging requests that coalesced into an already pending increment.
module counter_increment_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int N          = 4,
  parameter int CW         = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  request,
  output logic          increase,
  output logic [N-1:0]  grant,
  output logic [N-1:0]  pending,
  output logic          busy,
  output logic [CW-1:0] total
`ifdef CNT_ARB_DROP_DETECT_EN
  ,
  output logic [N-1:0]  dropped
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [GAP_W-1:0] gap_cnt;
  logic [N-1:0]     sel_onehot;
  logic [IW-1:0]    sel_idx;
  logic [N-1:0]     clear_mask;

  rr_priority_select #(.N(N), .IW(IW)) u_sel (
    .req    (pending),
    .base   (rr_ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  // The served bit is cleared at the PULSE exit edge; grant is onehot(winner) there.
  assign clear_mask = (state == PULSE) ? grant : '0;

  assign busy = (state != IDLE) || (|pending);

  // Latch requests; a request on the clearing edge re-arms the bit (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clear_mask) | request;
  end

`ifdef CNT_ARB_DROP_DETECT_EN
  // Sticky flag: a request merged into an increment that is still waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dropped <= '0;
    else        dropped <= dropped | (request & pending & ~clear_mask);
  end
`endif

  // Arbiter FSM with registered increase/grant; winner held through PULSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      increase <= 1'b0;
      grant    <= '0;
      winner   <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      total    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            winner   <= sel_idx;
            grant    <= sel_onehot;
            increase <= 1'b1;
            state    <= PULSE;
          end
        end
        PULSE: begin
          total    <= total + CW'(1);
          rr_ptr   <= (winner == LAST_IDX) ? '0 : winner + IW'(1);
          gap_cnt  <= GAP_LOAD;
          increase <= 1'b0;
          grant    <= '0;
          state    <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) begin
            if (|pending) begin
              winner   <= sel_idx;
              grant    <= sel_onehot;
              increase <= 1'b1;
              state    <= PULSE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          increase <= 1'b0;
          grant    <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
